pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Fetch-stage sequencer that consumes next-PC values (PC+4 or a redirect target), issues one instruction-memory read per PC, and delivers the returned instruction with its PC and PC+4 to decode.
- It is the reader/consumer end of the PC-increment path: it owns the PC register that the adder feeds.
- Sits between the instruction memory port and the IF/ID boundary of the RISC-V pipeline.

Parameters:
XLEN, 32, address and instruction width
RESET_VECTOR, 32'h00000000, PC value loaded on reset
PC_STEP, 4, sequential increment added to PC

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  XLEN  fetch address, always equals pc
imem_resp_valid  input  1  instruction data valid
imem_resp_data  input  XLEN  returned instruction word
redirect_valid  input  1  branch/jump redirect from execute
redirect_target  input  XLEN  redirect destination
id_valid  output  1  instruction available to decode
id_ready  input  1  decode accepts instruction
id_instr  output  XLEN  fetched instruction
id_pc  output  XLEN  PC of id_instr
id_pc_plus4  output  XLEN  id_pc + PC_STEP
misalign_err  output  1  one-cycle pulse: redirect target low 2 bits nonzero

Behaviour:
- Reset (rst=0 at clock edge): pc=RESET_VECTOR, state=REQ, drop=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, misalign_err=0. imem_req_valid is forced to 0 while rst=0.
- imem_addr = pc combinationally at all times. imem_req_valid = (state==REQ) && rst.
- Only one request is outstanding at a time. The response always arrives in a later cycle than the accepting handshake.
- States:
  - REQ: imem_req_valid=1. On imem_req_ready go to WAIT; otherwise stay in REQ (hold address stable).
  - WAIT: on imem_resp_valid with drop=0: id_instr<=imem_resp_data, id_pc<=pc, id_pc_plus4<=pc+PC_STEP, id_valid<=1, pc<=pc+PC_STEP, go to HOLD. On imem_resp_valid with drop=1: discard data, drop<=0, go to REQ.
  - HOLD: id_valid=1 and id outputs stable. On id_ready: id_valid<=0, go to REQ. The next request is issued the cycle after the handshake, so sustained throughput is one instruction per 3 cycles.
- Redirect has priority over all other events in the same cycle:
  - pc <= {redirect_target[XLEN-1:2], 2'b00}.
  - misalign_err <= (redirect_target[1:0]!=0) for exactly one cycle; otherwise 0.
  - REQ without handshake: stay in REQ; the new pc is presented next cycle.
  - REQ with imem_req_ready in the same cycle: the old-PC request is in flight; go to WAIT with drop=1.
  - WAIT, no response this cycle: drop<=1, stay in WAIT.
  - WAIT with imem_resp_valid in the same cycle: discard data, go to REQ, drop=0.
  - HOLD: id_valid<=0 (instruction killed even if id_ready=1), go to REQ.
- PC arithmetic is modulo 2^XLEN: pc=32'hFFFFFFFC advances to 32'h00000000, and id_pc_plus4 wraps the same way.
- Reset asserted mid-operation overrides everything. An in-flight memory response arriving after reset release is ignored, because the state machine is in REQ and only accepts responses in WAIT.

Test Plan:
- Reset release, memory always ready, one-cycle response latency, id_ready=1 -> first imem_addr=00000000; id_pc sequence 0,4,8 with id_pc_plus4 4,8,C; id_instr matches memory words.
- Hold id_ready=0 for 5 cycles after id_valid -> id_valid, id_instr and id_pc stable for all 5 cycles; no imem_req_valid during that time; next request for PC 4 starts the cycle after id_ready=1.
- Redirect to 00000100 in the same cycle as imem_req_ready for PC 8 -> response for PC 8 discarded (id_valid stays 0); next imem_addr=00000100; id_pc=00000100.
- Redirect to 00000042 while in HOLD with id_ready=1 -> misalign_err high for one cycle; held instruction never handshaken; next imem_addr=00000040.
- RESET_VECTOR=FFFFFFFC -> first id_pc=FFFFFFFC, id_pc_plus4=00000000; next fetch address 00000000.
- rst=0 asserted while in WAIT, then a late imem_resp_valid after release -> all outputs 0 during reset; late response ignored; first request after release is for RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage sequencer: owns the PC, issues one instruction-memory read per PC,
// and presents the returned word with its PC and PC+step to decode.
module pc_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            misalign_err,
  output logic [1:0]      fetch_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and payload is held stable while valid waits for ready.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t          state;
  logic            drop;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] target_aligned;

  assign pc_seq         = pc + STEP;
  assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};
  assign imem_addr      = pc;
  assign imem_req_valid = (state == ST_REQ) && rst;
  assign fetch_state    = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc           <= RESET_VECTOR;
      state        <= ST_REQ;
      drop         <= 1'b0;
      id_valid     <= 1'b0;
      id_instr     <= '0;
      id_pc        <= '0;
      id_pc_plus4  <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // A redirect wins over every other event; anything already fetched for the
      // old path is either killed in HOLD or marked for discard while in flight.
      pc           <= target_aligned;
      misalign_err <= (redirect_target[1:0] != 2'b00);
      case (state)
        ST_REQ: begin
          if (imem_req_ready) begin
            state <= ST_WAIT;
            drop  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state <= ST_REQ;
            drop  <= 1'b0;
          end else begin
            drop <= 1'b1;
          end
        end
        ST_HOLD: begin
          id_valid <= 1'b0;
          state    <= ST_REQ;
        end
        default: state <= ST_REQ;
      endcase
    end else begin
      misalign_err <= 1'b0;
      case (state)
        ST_REQ: begin
          if (imem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              id_instr    <= imem_resp_data;
              id_pc       <= pc;
              id_pc_plus4 <= pc_seq;
              id_valid    <= 1'b1;
              pc          <= pc_seq;
              state       <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            id_valid <= 1'b0;
            state    <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule
